// File: rtl/uart_transmitter.sv
// uart_transmitter: 8N1 serial transmitter with a one-entry holding register for back-to-back frames.
module uart_transmitter #(
  parameter int FREQ      = 24_000_000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] DATA_byte,
  output logic       DATA_serial,
  output logic       ready,
  output logic       busy,
  output logic       done_tick
);
  localparam int CLKS_PER_BIT = FREQ / BAUD_RATE;
  localparam int CW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  typedef enum logic [1:0] {IDLE, START_BIT, DATA_TRANSFER, STOP_BIT} state_t;
  state_t state, state_d;
  logic [CW-1:0] clk_counter, cnt_d;
  logic [2:0] bit_index, idx_d;
  logic [7:0] shift, shift_d, hold, hold_d;
  logic hold_valid, hv_d, ser_d, last, accept;
  assign last   = clk_counter == LAST;
  assign accept = start && !hold_valid;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      clk_counter <= '0;
      bit_index   <= '0;
      shift       <= '0;
      hold        <= '0;
      hold_valid  <= 1'b0;
      DATA_serial <= 1'b1;
    end else begin
      state       <= state_d;
      clk_counter <= cnt_d;
      bit_index   <= idx_d;
      shift       <= shift_d;
      hold        <= hold_d;
      hold_valid  <= hv_d;
      DATA_serial <= ser_d;
    end
  end
  always_comb begin
    state_d = state;
    cnt_d   = last ? '0 : clk_counter + 1'b1;
    idx_d   = bit_index;
    shift_d = shift;
    hold_d  = hold;
    hv_d    = hold_valid;
    case (state)
      IDLE: begin
        cnt_d = '0;
        if (accept) begin
          state_d = START_BIT;
          shift_d = DATA_byte;
        end
      end
      START_BIT: if (last) begin
        idx_d   = '0;
        state_d = DATA_TRANSFER;
      end
      DATA_TRANSFER: if (last) begin
        idx_d   = bit_index + 1'b1;
        state_d = (bit_index == 3'd7) ? STOP_BIT : DATA_TRANSFER;
      end
      STOP_BIT: if (last) begin
        if (hold_valid) begin
          shift_d = hold;
          hv_d    = 1'b0;
          state_d = START_BIT;
        end else if (accept) begin
          shift_d = DATA_byte;
          state_d = START_BIT;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // A byte arriving on the final stop edge with an empty holder goes straight to the shifter.
    if (state != IDLE && accept && !(state == STOP_BIT && last)) begin
      hold_d = DATA_byte;
      hv_d   = 1'b1;
    end
  end
  always_comb begin
    ser_d     = (state_d == START_BIT) ? 1'b0 : (state_d == DATA_TRANSFER) ? shift_d[idx_d] : 1'b1;
    ready     = !hold_valid;
    busy      = state != IDLE;
    done_tick = state == STOP_BIT && last;
  end
endmodule

// File: tb/tb_uart_transmitter.sv
// tb_uart_transmitter: frame-level reference model plus directed table and corner-case sequences.
module tb_uart_transmitter;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0;
  logic [7:0] DATA_byte = 8'h00;
  logic DATA_serial, ready, busy, done_tick;
  int errors = 0, checks = 0, cyc = 0;
  bit m_active = 0, m_qv = 0;
  int m_pos = 0;
  logic [7:0] m_cb = 0, m_qb = 0;

  uart_transmitter #(.FREQ(1000), .BAUD_RATE(100)) dut (
    .clk(clk), .reset(reset), .start(start), .DATA_byte(DATA_byte),
    .DATA_serial(DATA_serial), .ready(ready), .busy(busy), .done_tick(done_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    int gap;
    logic [7:0] b;
    logic exp_ready;
    logic exp_busy;
  } vec_t;

  function automatic logic fbit(input logic [7:0] b, input int k);
    return (k == 0) ? 1'b0 : (k == 9) ? 1'b1 : b[k-1];
  endfunction

  task automatic chk(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %b want %b", name, cyc, act, exp);
    end
  endtask

  task automatic model_edge(input logic s, input logic [7:0] b);
    bit acc;
    acc = s && !m_qv;
    if (m_active) begin
      if (m_pos == 99) begin
        if (m_qv) begin m_cb = m_qb; m_qv = 0; m_pos = 0; end
        else if (acc) begin m_cb = b; m_pos = 0; end
        else m_active = 0;
      end else begin
        m_pos++;
        if (acc) begin m_qv = 1; m_qb = b; end
      end
    end else if (acc) begin
      m_active = 1; m_pos = 0; m_cb = b;
    end
  endtask

  task automatic step(input logic s, input logic [7:0] b);
    logic [3:0] e, a;
    @(negedge clk);
    start = s;
    DATA_byte = b;
    model_edge(s, b);
    @(posedge clk);
    #1;
    cyc++;
    e = {m_active ? fbit(m_cb, m_pos / 10) : 1'b1, !m_qv, m_active, m_active && m_pos == 99};
    a = {DATA_serial, ready, busy, done_tick};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL model cycle %0d: got %b want %b (serial,ready,busy,done)", cyc, a, e);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'($urandom));
  endtask

  vec_t vt[6];
  initial begin
    vt[0] = '{3,   8'hA5, 1'b1, 1'b0};
    vt[1] = '{120, 8'h55, 1'b1, 1'b0};
    vt[2] = '{30,  8'h0F, 1'b1, 1'b1};
    vt[3] = '{250, 8'h11, 1'b1, 1'b0};
    vt[4] = '{20,  8'h22, 1'b1, 1'b1};
    vt[5] = '{20,  8'h33, 1'b0, 1'b1};
    repeat (2) @(negedge clk);
    chk("rst_serial", DATA_serial, 1'b1);
    chk("rst_ready", ready, 1'b1);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done_tick, 1'b0);
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      idle(vt[i].gap);
      chk($sformatf("vec%0d_ready", i), ready, vt[i].exp_ready);
      chk($sformatf("vec%0d_busy", i), busy, vt[i].exp_busy);
      step(1'b1, vt[i].b);
    end
    idle(250);
    step(1'b1, 8'h3C);
    begin
      int n = 0;
      while (!done_tick && n < 200) begin step(1'b0, 8'h00); n++; end
      chk("coinc_done_seen", done_tick, 1'b1);
    end
    step(1'b1, 8'hC3);
    chk("coinc_busy", busy, 1'b1);
    chk("coinc_ready", ready, 1'b1);
    chk("coinc_line_low", DATA_serial, 1'b0);
    idle(150);
    step(1'b1, 8'h77);
    idle(40);
    reset = 1'b1;
    #1;
    chk("midrst_serial", DATA_serial, 1'b1);
    chk("midrst_busy", busy, 1'b0);
    chk("midrst_ready", ready, 1'b1);
    m_active = 0; m_qv = 0; m_pos = 0;
    @(negedge clk);
    reset = 1'b0;
    step(1'b1, 8'h5A);
    idle(110);
    for (int i = 0; i < 1500; i++) step(($urandom % 8) == 0, 8'($urandom));
    idle(250);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_transmitter.md
Name: uart_transmitter

Overview:
- 8N1 UART serial transmitter; the transmit-side counterpart to the team's UART receiver, using the same FREQ/BAUD_RATE parameterisation.
- Accepts bytes over a start/ready handshake and serialises them onto DATA_serial.
- Has a one-entry holding register, so a second byte can be queued during a frame and sent back-to-back with no idle gap.
- Sits between the command/LCD-control logic and the board TX pin.

Parameters:
- FREQ, 24_000_000, system clock frequency in Hz.
- BAUD_RATE, 9600, serial bit rate.
- Derived constant CLKS_PER_BIT = FREQ/BAUD_RATE (integer division, 2500 at defaults); must be >= 2.
- Bit counter width: $clog2(CLKS_PER_BIT), minimum 1.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  asynchronous, active-high reset.
- start  input  1  byte-valid strobe; accepted on any posedge where start=1 and ready=1.
- DATA_byte  input  8  byte to transmit; sampled only on an accepting edge.
- DATA_serial  output  1  serial line; idles high; registered output.
- ready  output  1  1 = a byte can be accepted this cycle (holding register empty).
- busy  output  1  1 = a frame is in progress (STATE != IDLE).
- done_tick  output  1  one-cycle pulse on the last cycle of each stop bit.

Behaviour:
- Reset values (asynchronous): DATA_serial=1, ready=1, busy=0, done_tick=0; STATE=IDLE; clk_counter, bit_index, shift register and holding register all 0; hold_valid=0.
- Reset mid-frame: the line returns high immediately and the frame is abandoned. No done_tick is generated for it.
- States: IDLE, START_BIT, DATA_TRANSFER, STOP_BIT. Encoding is 2-bit; unreachable codes go to IDLE.
- IDLE:
  - DATA_serial=1.
  - Accepting edge: DATA_byte loads the shift register, STATE goes to START_BIT, clk_counter=0.
  - DATA_serial is 0 from the following cycle (1-cycle latency start->line low).
- START_BIT:
  - DATA_serial=0 for exactly CLKS_PER_BIT cycles.
  - When clk_counter reaches CLKS_PER_BIT-1: counter goes to 0, bit_index to 0, STATE to DATA_TRANSFER.
- DATA_TRANSFER:
  - DATA_serial = shift register bit[bit_index], LSB first.
  - Each bit is held exactly CLKS_PER_BIT cycles.
  - After bit 7 completes, STATE goes to STOP_BIT.
- STOP_BIT:
  - DATA_serial=1 for exactly CLKS_PER_BIT cycles.
  - done_tick=1 only on the cycle where clk_counter = CLKS_PER_BIT-1.
  - On that edge: if hold_valid=1, the holding register moves to the shift register, hold_valid clears, and STATE goes to START_BIT; otherwise STATE goes to IDLE.
- Frame length: exactly 10*CLKS_PER_BIT cycles from first low cycle to end of stop bit.
- Holding register:
  - When STATE != IDLE and ready=1, an accepting edge stores DATA_byte in the holding register and sets hold_valid.
  - ready = !hold_valid.
- start while ready=0: ignored; the byte is dropped with no side effects. The producer must wait for ready.
- Simultaneous events:
  - start on the final STOP_BIT edge with hold_valid=0: the byte loads directly into the shift register and STATE goes to START_BIT (back-to-back, no gap).
  - start on the final STOP_BIT edge with hold_valid=1: ignored (ready=0).
- done_tick and an accepting start may coincide; both take effect.
- DATA_byte changes after acceptance do not affect the frame in flight or the queued byte.
- busy is 1 from the cycle after acceptance in IDLE through the final STOP_BIT cycle. During back-to-back frames busy stays 1 continuously.

Test Plan (FREQ=1000, BAUD_RATE=100, CLKS_PER_BIT=10):
- Reset -> DATA_serial=1, ready=1, busy=0, done_tick=0. Assert reset mid-frame -> line high in the same cycle, busy=0; the next byte transmits correctly.
- Single byte 0xA5: one-cycle start pulse -> line low 10 cycles, then 1,0,1,0,0,1,0,1 at 10 cycles per bit, then high 10 cycles. done_tick=1 exactly on cycle 100 of the frame, then busy=0.
- Back-to-back 0x55 then 0x0F: second start 30 cycles into the first frame -> ready=0 until the first stop bit ends. The second frame's start bit begins the cycle immediately after the first stop bit; two done_ticks 100 cycles apart.
- Overflow: 0x11 sent, 0x22 queued, 0x33 strobed while ready=0 -> only 0x11 and 0x22 appear on the line; 0x33 is never transmitted.
- Coincident start on the final stop-bit cycle with an empty holder: 0xC3 -> no idle gap; 0xC3 frame follows immediately; done_tick and acceptance on the same edge.
- Loopback into the existing UART receiver at defaults (24 MHz, 9600): bytes 0x00, 0xFF, 0x7E -> the receiver's DATA_byte matches each byte on every receiver done_tick.
